// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop,
// LSB first, WIDTH cycles per operation under a start/done handshake.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_c;
  logic             co_c;
  logic             last_c;
  logic [WIDTH-1:0] res_nxt_c;

  // Full-adder slice on the operand LSBs and the shifted result word
  assign s_c       = opa[0] ^ opb[0] ^ carry;
  assign co_c      = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
  assign last_c    = (cnt == CW'(WIDTH - 1));
  assign res_nxt_c = {s_c, res[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered handshake outputs follow the upcoming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
    end
  end

  // Operand capture, serial datapath and result publication
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            res   <= '0;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= {1'b0, opa[WIDTH-1:1]};
          opb   <= {1'b0, opb[WIDTH-1:1]};
          res   <= res_nxt_c;
          carry <= co_c;
          cnt   <= cnt + CW'(1);
          // carry here is the carry into the MSB
          if (last_c) begin
            sum   <= res_nxt_c;
            c_out <= co_c;
            ovf   <= carry ^ co_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): timeline-based reference
// model compared every cycle, plus directed cases with literal expectations.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Arithmetic reference: plain integer add/subtract
  task automatic calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      output logic [W-1:0] r, output logic c, output logic o);
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 2**(W-1)) ? ux - 2**W : ux;
    sy = (uy >= 2**(W-1)) ? uy - 2**W : uy;
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      c  = (ux >= uy);
    end else begin
      ur = ux + uy;
      sr = sx + sy;
      c  = (ur >= 2**W);
    end
    r = W'((ur + 2**W) % (2**W));
    o = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
  endtask

  // Model: t = edges since capture (-1 when idle)
  int           m_t = -1;
  logic [W-1:0] m_sum = '0, p_sum;
  logic         m_c = 1'b0, m_o = 1'b0, p_c, p_o;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_t   = -1;
      m_sum = '0;
      m_c   = 1'b0;
      m_o   = 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
        calc(a, b, sub, p_sum, p_c, p_o);
        m_t = 0;
      end
    end else if (m_t == W) begin
      m_t = -1;
    end else begin
      m_t++;
      if (m_t == W) begin
        m_sum = p_sum;
        m_c   = p_c;
        m_o   = p_o;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("model_busy",  32'(busy),  32'((m_t >= 0) && (m_t < W)));
      chk("model_done",  32'(done),  32'(m_t == W));
      chk("model_sum",   32'(sum),   32'(m_sum));
      chk("model_c_out", 32'(c_out), 32'(m_c));
      chk("model_ovf",   32'(ovf),   32'(m_o));
    end
  end

  // Pulse start for one cycle, wait bounded for done, check literal results
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input string nm);
    int bcnt;
    int k;
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    k = 0;
    while (!done && k < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      k++;
    end
    chk({nm, "_done"},  32'(done),  32'd1);
    chk({nm, "_busyn"}, 32'(bcnt),  32'(W));
    chk({nm, "_sum"},   32'(sum),   32'(es));
    chk({nm, "_c_out"}, 32'(c_out), 32'(ec));
    chk({nm, "_ovf"},   32'(ovf),   32'(eo));
  endtask

  initial begin
    int ndone;
    int last_done;
    logic [W-1:0] got_sum;

    rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 8'hFF; b = 8'h01;

    // Reset held with start high: nothing captured
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum),   32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_nocap", 32'(busy), 32'd0);

    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_carry");
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf_pos");
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add_ovf_neg");
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow");
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");
    do_op(8'h33, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, "sub_zero");

    // Start pulsed and operands changed during RUN: ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; got_sum = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        got_sum = sum;
      end
      @(negedge clk);
    end
    chk("hs_one_done", 32'(ndone), 32'd1);
    chk("hs_sum",      32'(got_sum), 32'h30);
    chk("hs_c_out",    32'(c_out), 32'd0);
    chk("hs_ovf",      32'(ovf),   32'd0);

    // Start held high: one done per W+2 cycles
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    ndone = 0; last_done = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        if (last_done >= 0) chk("held_period", 32'(cyc - last_done), 32'(W + 2));
        last_done = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    chk("held_count", 32'(ndone >= 4), 32'd1);
    repeat (12) @(negedge clk);

    // Reset in the 4th RUN cycle: no done, outputs cleared
    a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum",  32'(sum),  32'd0);
    chk("mid_rst_c",    32'(c_out), 32'd0);
    chk("mid_rst_ovf",  32'(ovf),  32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);

    // Random traffic: random start, operands and rare resets, model-checked
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (15) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
